// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode, flag and control-width definitions shared by the pipelined ALU
package alu_pkg;

    localparam int ALU_CTRL_W = 4;

    typedef enum logic [ALU_CTRL_W-1:0] {
        OP_ADD    = 4'd0,
        OP_SUB    = 4'd1,
        OP_AND    = 4'd2,
        OP_OR     = 4'd3,
        OP_XOR    = 4'd4,
        OP_SLL    = 4'd5,
        OP_SRL    = 4'd6,
        OP_SRA    = 4'd7,
        OP_SLT    = 4'd8,
        OP_SLTU   = 4'd9,
        OP_PASS_B = 4'd10,
        OP_MUL    = 4'd11
    } alu_op_e;

    typedef struct packed {
        logic Zero;
        logic LessThan;
        logic LessThanUnsigned;
        logic illegal;
    } alu_flags_t;

endpackage

// File: rtl/alu_pipe_if.sv
// rtl/alu_pipe_if.sv - issue/result handshake bundle between issue logic and alu_pipe
interface alu_pipe_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    logic                           in_valid;
    logic                           in_ready;
    logic [WIDTH-1:0]               a;
    logic [WIDTH-1:0]               b;
    logic [alu_pkg::ALU_CTRL_W-1:0] ALUControl;
    logic [TAG_W-1:0]               in_tag;
    logic                           flush;
    logic                           out_valid;
    logic                           out_ready;
    logic [WIDTH-1:0]               ALUResult;
    logic                           Zero;
    logic                           LessThan;
    logic                           LessThanUnsigned;
    logic [TAG_W-1:0]               out_tag;
    logic                           out_illegal;

    modport master (
        output in_valid, a, b, ALUControl, in_tag, flush, out_ready,
        input  in_ready, out_valid, ALUResult, Zero, LessThan, LessThanUnsigned,
               out_tag, out_illegal
    );

    modport slave (
        input  in_valid, a, b, ALUControl, in_tag, flush, out_ready,
        output in_ready, out_valid, ALUResult, Zero, LessThan, LessThanUnsigned,
               out_tag, out_illegal
    );
endinterface

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational ALU result and flags; opcode 11 is MUL only when ALU_PIPE_MUL_EN is defined
module alu_core import alu_pkg::*; #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]      a,
    input  logic [WIDTH-1:0]      b,
    input  logic [ALU_CTRL_W-1:0] ALUControl,
    output logic [WIDTH-1:0]      ALUResult,
    output alu_flags_t            flags
);
    localparam int SHW = $clog2(WIDTH);

    alu_op_e        op;
    logic [SHW-1:0] shamt;
    logic           lt;
    logic           ltu;

    assign op    = alu_op_e'(ALUControl);
    assign shamt = b[SHW-1:0];
    assign lt    = $signed(a) < $signed(b);
    assign ltu   = a < b;

    always_comb begin
        ALUResult     = '0;
        flags         = '0;
        flags.illegal = 1'b0;
        case (op)
            OP_ADD:    ALUResult = a + b;
            OP_SUB:    ALUResult = a - b;
            OP_AND:    ALUResult = a & b;
            OP_OR:     ALUResult = a | b;
            OP_XOR:    ALUResult = a ^ b;
            OP_SLL:    ALUResult = a << shamt;
            OP_SRL:    ALUResult = a >> shamt;
            OP_SRA:    ALUResult = WIDTH'($signed(a) >>> shamt);
            OP_SLT:    ALUResult = WIDTH'(lt);
            OP_SLTU:   ALUResult = WIDTH'(ltu);
            OP_PASS_B: ALUResult = b;
`ifdef ALU_PIPE_MUL_EN
            OP_MUL:    ALUResult = a * b;
`endif
            default:   flags.illegal = 1'b1;
        endcase
        // compare flags are reported for every opcode so branches can use them
        flags.Zero             = (ALUResult == '0);
        flags.LessThan         = lt;
        flags.LessThanUnsigned = ltu;
    end

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - LATENCY-stage elastic ALU pipeline with tag pass-through and flush
module alu_pipe import alu_pkg::*; #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 2,
    parameter int TAG_W   = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_pipe_if.slave bus
);
    typedef struct packed {
        logic [WIDTH-1:0] result;
        alu_flags_t       flags;
        logic [TAG_W-1:0] tag;
    } stage_t;

    logic [WIDTH-1:0]   core_res;
    alu_flags_t         core_flags;
    stage_t             stg [LATENCY];
    stage_t             src [LATENCY];
    logic [LATENCY-1:0] v;
    logic [LATENCY-1:0] load;
    logic [LATENCY-1:0] src_v;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a          (bus.a),
        .b          (bus.b),
        .ALUControl (bus.ALUControl),
        .ALUResult  (core_res),
        .flags      (core_flags)
    );

    // ready ripples back from the consumer so a full pipe can accept while draining
    always_comb begin
        logic rdy;
        rdy  = bus.out_ready;
        load = '0;
        for (int i = LATENCY - 1; i >= 0; i--) begin
            rdy     = !v[i] || rdy;
            load[i] = rdy;
        end
    end

    always_comb begin
        src_v    = '0;
        src      = '{default: '0};
        src_v[0] = bus.in_valid;
        src[0]   = {core_res, core_flags, bus.in_tag};
        for (int i = 1; i < LATENCY; i++) begin
            src_v[i] = v[i-1];
            src[i]   = stg[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                stg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LATENCY; i++) begin
                if (bus.flush) begin
                    v[i] <= 1'b0;
                end else if (load[i]) begin
                    v[i] <= src_v[i];
                    if (src_v[i]) begin
                        stg[i] <= src[i];
                    end
                end
            end
        end
    end

    assign bus.in_ready         = rst_n && load[0];
    assign bus.out_valid        = v[LATENCY-1];
    assign bus.ALUResult        = stg[LATENCY-1].result;
    assign bus.Zero             = stg[LATENCY-1].flags.Zero;
    assign bus.LessThan         = stg[LATENCY-1].flags.LessThan;
    assign bus.LessThanUnsigned = stg[LATENCY-1].flags.LessThanUnsigned;
    assign bus.out_illegal      = stg[LATENCY-1].flags.illegal;
    assign bus.out_tag          = stg[LATENCY-1].tag;

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - randomized scoreboard bench for alu_pipe, follows ALU_PIPE_MUL_EN
module tb_alu_pipe;
    import alu_pkg::*;

    localparam int W   = 32;
    localparam int LAT = 2;
    localparam int TW  = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_pipe_if #(.WIDTH(W), .TAG_W(TW)) bus ();
    alu_pipe #(.WIDTH(W), .LATENCY(LAT), .TAG_W(TW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    alu_pipe_if #(.WIDTH(8), .TAG_W(TW)) bus8 ();
    alu_pipe #(.WIDTH(8), .LATENCY(1), .TAG_W(TW)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_cyc = 0, n_acc = 0, n_out = 0, acc_cyc = 0, out_cyc = 0;
    logic        seen_ready, seen_valid, seen_acc;
    logic [71:0] pend [$];     // {op, a, b, tag} waiting to be accepted
    logic [39:0] exp_q [$];    // {result, Zero, LessThan, LessThanUnsigned, illegal, tag}
    logic [39:0] last_out;
    int          tag_log [$];
    int          cyc_log [$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [39:0] ref_alu(input logic [71:0] w);
        logic [3:0]  op;
        logic [3:0]  tag;
        int          sa, sb, sh;
        int unsigned ua, ub;
        logic [31:0] r;
        logic        ill;
        op  = w[71:68];
        ua  = w[67:36];
        ub  = w[35:4];
        tag = w[3:0];
        sa  = ua;
        sb  = ub;
        sh  = int'(ub % 32);
        r   = 0;
        ill = 1'b0;
        case (op)
            4'd0:  r = ua + ub;
            4'd1:  r = ua - ub;
            4'd2:  r = ua & ub;
            4'd3:  r = ua | ub;
            4'd4:  r = ua ^ ub;
            4'd5:  r = ua << sh;
            4'd6:  r = ua >> sh;
            4'd7:  r = sa >>> sh;
            4'd8:  r = (sa < sb) ? 32'd1 : 32'd0;
            4'd9:  r = (ua < ub) ? 32'd1 : 32'd0;
            4'd10: r = ub;
`ifdef ALU_PIPE_MUL_EN
            4'd11: r = ua * ub;
`endif
            default: ill = 1'b1;
        endcase
        return {r, (r == 32'd0), (sa < sb), (ua < ub), ill, tag};
    endfunction

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(5))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // one clock: drive at negedge, sample 1ns before posedge, return at next negedge
    task automatic cycle();
        logic [39:0] got;
        if (pend.size() > 0) begin
            bus.in_valid = 1'b1;
            {bus.ALUControl, bus.a, bus.b, bus.in_tag} = pend[0];
        end else begin
            bus.in_valid = 1'b0;
        end
        #4;
        n_cyc++;
        seen_ready = bus.in_ready;
        seen_valid = bus.out_valid;
        seen_acc   = bus.in_valid && bus.in_ready;
        if (bus.out_valid) begin
            check("out_pending", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                got = {bus.ALUResult, bus.Zero, bus.LessThan, bus.LessThanUnsigned,
                       bus.out_illegal, bus.out_tag};
                check("out_data", got, exp_q[0]);
                if (bus.out_ready && !bus.flush) begin
                    void'(exp_q.pop_front());
                    last_out = got;
                    n_out++;
                    out_cyc = n_cyc;
                    tag_log.push_back(int'(bus.out_tag));
                    cyc_log.push_back(n_cyc);
                end
            end
        end
        if (bus.flush) exp_q.delete();
        if (seen_acc) begin
            n_acc++;
            acc_cyc = n_cyc;
            if (!bus.flush) exp_q.push_back(ref_alu(pend[0]));
            void'(pend.pop_front());
        end
        @(negedge clk);
    endtask

    task automatic run_one(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] tag);
        int n0;
        n0 = n_out;
        pend.push_back({op, a, b, tag});
        bus.out_ready = 1'b1;
        bus.flush     = 1'b0;
        for (int k = 0; k < 20 && n_out == n0; k++) cycle();
        check("run_one_done", 64'(n_out - n0), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, a0;
        rst_n = 1'b0;
        bus.in_valid = 0; bus.a = '0; bus.b = '0; bus.ALUControl = '0; bus.in_tag = '0;
        bus.flush = 0; bus.out_ready = 0;
        bus8.in_valid = 0; bus8.a = '0; bus8.b = '0; bus8.ALUControl = '0; bus8.in_tag = '0;
        bus8.flush = 0; bus8.out_ready = 0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_outputs", 64'({bus.ALUResult, bus.Zero, bus.LessThan, bus.LessThanUnsigned,
                                  bus.out_illegal, bus.out_tag}), 64'd0);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);

        run_one(4'd0, 32'h7FFF_FFFF, 32'd1, 4'd3);
        check("add_res", 64'(last_out[39:8]), 64'h8000_0000);
        check("add_flags", 64'(last_out[7:4]), 64'b0000);
        check("add_tag", 64'(last_out[3:0]), 64'd3);
        check("add_latency", 64'(out_cyc - acc_cyc), 64'(LAT));

        run_one(4'd1, 32'd5, 32'd5, 4'd4);
        check("sub_res", 64'(last_out[39:8]), 64'd0);
        check("sub_zero", 64'(last_out[7]), 64'd1);

        run_one(4'd8, 32'hFFFF_FFFF, 32'd1, 4'd5);
        check("slt_res", 64'(last_out[39:8]), 64'd1);
        check("slt_flags", 64'(last_out[7:4]), 64'b0100);

        run_one(4'd7, 32'h8000_0000, 32'd36, 4'd6);
        check("sra_res", 64'(last_out[39:8]), 64'hF800_0000);

        run_one(4'd11, 32'd3, 32'd5, 4'd7);
`ifdef ALU_PIPE_MUL_EN
        check("mul_res", 64'(last_out[39:8]), 64'd15);
        check("mul_illegal", 64'(last_out[4]), 64'd0);
`else
        check("op11_res", 64'(last_out[39:8]), 64'd0);
        check("op11_illegal", 64'(last_out[4]), 64'd1);
`endif
        run_one(4'd14, 32'd3, 32'd5, 4'd8);
        check("op14_res", 64'(last_out[39:8]), 64'd0);
        check("op14_flags", 64'(last_out[7:4]), 64'b1111);

        // backpressure: tags 1..4 against a stalled consumer
        bus.out_ready = 1'b0;
        a0 = n_acc;
        for (int t = 1; t <= 4; t++) pend.push_back({4'd0, 32'(t), 32'd10, 4'(t)});
        repeat (5) cycle();
        check("stall_accepts", 64'(n_acc - a0), 64'(LAT));
        check("stall_in_ready", 64'(seen_ready), 64'd0);
        check("stall_out_valid", 64'(seen_valid), 64'd1);
        tag_log.delete();
        cyc_log.delete();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 12 && tag_log.size() < 4; k++) cycle();
        check("stall_count", 64'(tag_log.size()), 64'd4);
        for (int i = 0; i < tag_log.size() && i < 4; i++) begin
            check("stall_tag", 64'(tag_log[i]), 64'(i + 1));
            if (i > 0) check("stall_b2b", 64'(cyc_log[i] - cyc_log[0]), 64'(i));
        end

        // flush with two in flight and one accepted in the flush cycle
        bus.out_ready = 1'b0;
        n0 = n_out;
        for (int t = 5; t <= 7; t++) pend.push_back({4'd2, 32'hFF, 32'(t), 4'(t)});
        cycle();
        cycle();
        bus.flush = 1'b1;
        bus.out_ready = 1'b1;
        cycle();
        check("flush_acc", 64'(seen_acc), 64'd1);
        bus.flush = 1'b0;
        cycle();
        check("flush_out_valid", 64'(seen_valid), 64'd0);
        repeat (5) cycle();
        check("flush_no_out", 64'(n_out - n0), 64'd0);

        // asynchronous reset with work in flight
        bus.out_ready = 1'b0;
        n0 = n_out;
        pend.push_back({4'd0, 32'd1, 32'd1, 4'd9});
        pend.push_back({4'd0, 32'd2, 32'd2, 4'd10});
        cycle();
        cycle();
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 64'(bus.out_valid), 64'd0);
        check("rst_mid_ready", 64'(bus.in_ready), 64'd0);
        check("rst_mid_res", 64'(bus.ALUResult), 64'd0);
        exp_q.delete();
        pend.delete();
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (4) cycle();
        check("rst_mid_no_out", 64'(n_out - n0), 64'd0);

        // WIDTH=8, LATENCY=1 instance
        bus8.ALUControl = 4'd5; bus8.a = 8'h01; bus8.b = 8'h0F; bus8.in_tag = 4'd9;
        bus8.in_valid = 1'b1; bus8.out_ready = 1'b1;
        #4;
        check("w8_in_ready", 64'(bus8.in_ready), 64'd1);
        @(negedge clk);
        bus8.in_valid = 1'b0;
        #4;
        check("w8_out_valid", 64'(bus8.out_valid), 64'd1);
        check("w8_sll", 64'(bus8.ALUResult), 64'h80);
        check("w8_tag", 64'(bus8.out_tag), 64'd9);
        @(negedge clk);

        // randomized traffic with backpressure and occasional flush
        for (int c = 0; c < 600; c++) begin
            if (pend.size() == 0 && $urandom_range(3) != 0)
                pend.push_back({4'($urandom_range(15)), rnd_word(), rnd_word(), 4'($urandom)});
            bus.out_ready = ($urandom_range(9) < 7);
            bus.flush     = ($urandom_range(59) == 0);
            cycle();
        end
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 30 && (exp_q.size() > 0 || pend.size() > 0); k++) cycle();
        check("drain_empty", 64'(exp_q.size() + pend.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
